is_uart_rx_param: RTL

Parametrised UART receiver, next generation of the fixed 8-bit/space-parity RX FSM. Configurable data width, parity mode and stop-bit count. Internal oversampled bit timing with mid-bit sampling and false-start rejection. Per-frame parity/framing error flags, sticky overrun flag, and a valid/ready output handshake toward the controller FIFO or register file.

---
 rtl/is_uart_rx_param.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/is_uart_rx_param.sv
// Oversampled UART receiver: DATA_W bits LSB first, optional parity, 1-2 stop bits, valid/ready output with sticky overrun.
// Frame is presented one clk after the last stop-bit sample; a frame arriving while one is still held is dropped. Define IS_UART_RX_MAJ_EN for 2-of-3 majority sampling.
module is_uart_rx_param #(
  parameter int DATA_W    = 8,
  parameter int OVS       = 16,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rxd_i,
  input  logic              os_ce_i,
  input  logic              rx_ready_i,
  input  logic              ovr_clr_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              rx_par_err_o,
  output logic              rx_frm_err_o,
  output logic              rx_ovr_o,
  output logic              rx_busy_o
);

  localparam int CNT_W = $clog2(OVS);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVS / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVS - 1);
  localparam logic [3:0] DBIT_LAST = 4'(DATA_W - 1);
  localparam logic [3:0] SBIT_LAST = 4'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_WEND  = 3'd5;

  logic              sync1_q, sync2_q, rxs;
  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        bcnt_q, bcnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_err_q, par_err_d;
  logic              frm_err_q, frm_err_d;
  logic              bit_s;
  logic              par_exp;
  logic              deliver;
  logic              dlv_frm;

  logic [DATA_W-1:0] data_q;
  logic              valid_q, perr_q, ferr_q, ovr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd_i;
      sync2_q <= sync1_q;
    end
  end

  assign rxs = sync2_q;

`ifdef IS_UART_RX_MAJ_EN
  // Two previous tick samples; together with rxs at the sampling tick they vote.
  logic vote0_q, vote1_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vote0_q <= 1'b1;
      vote1_q <= 1'b1;
    end else if (os_ce_i) begin
      vote0_q <= rxs;
      vote1_q <= vote0_q;
    end
  end

  assign bit_s = (vote0_q & vote1_q) | (vote0_q & rxs) | (vote1_q & rxs);
`else
  assign bit_s = rxs;
`endif

  always_comb begin
    case (PARITY)
      1:       par_exp = ^shreg_q;
      2:       par_exp = ~^shreg_q;
      3:       par_exp = 1'b1;
      default: par_exp = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bcnt_d    = bcnt_q;
    shreg_d   = shreg_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    deliver   = 1'b0;
    dlv_frm   = frm_err_q;

    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (os_ce_i) begin
          if (cnt_q == CNT_MID) begin
            if (bit_s) begin
              state_d = S_IDLE;
            end else begin
              state_d   = S_DATA;
              cnt_d     = '0;
              bcnt_d    = '0;
              par_err_d = 1'b0;
              frm_err_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_DATA: begin
        if (os_ce_i) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            shreg_d = {bit_s, shreg_q[DATA_W-1:1]};
            if (bcnt_q == DBIT_LAST) begin
              bcnt_d  = '0;
              state_d = (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              bcnt_d = bcnt_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_PAR: begin
        if (os_ce_i) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            bcnt_d    = '0;
            par_err_d = (bit_s != par_exp);
            state_d   = S_STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_STOP: begin
        if (os_ce_i) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            frm_err_d = frm_err_q | ~bit_s;
            if (bcnt_q == SBIT_LAST) begin
              deliver = 1'b1;
              dlv_frm = frm_err_q | ~bit_s;
              bcnt_d  = '0;
              // A low last stop bit may be a break; hold off until the line recovers.
              state_d = bit_s ? S_IDLE : S_WEND;
            end else begin
              bcnt_d = bcnt_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_WEND: begin
        if (rxs) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bcnt_q    <= '0;
      shreg_q   <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bcnt_q    <= bcnt_d;
      shreg_q   <= shreg_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (deliver && (!valid_q || rx_ready_i)) begin
        data_q  <= shreg_q;
        perr_q  <= par_err_q;
        ferr_q  <= dlv_frm;
        valid_q <= 1'b1;
      end else if (valid_q && rx_ready_i) begin
        valid_q <= 1'b0;
      end

      // Setting beats clearing when both land in the same cycle.
      if (deliver && valid_q && !rx_ready_i) begin
        ovr_q <= 1'b1;
      end else if (ovr_clr_i) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign rx_data_o    = data_q;
  assign rx_valid_o   = valid_q;
  assign rx_par_err_o = perr_q;
  assign rx_frm_err_o = ferr_q;
  assign rx_ovr_o     = ovr_q;
  assign rx_busy_o    = (state_q != S_IDLE);

endmodule
